mem_ctrl: RTL

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_if.sv | 11 +
 rtl/mem_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_if.sv
// Line-memory bus between a requester and mem_ctrl: address, shared
// command/response and data lines, and the controller's BUSY flag.
interface mem_ctrl_if;
   logic [14:0] A2;
   wire  [1:0]  C2;
   wire  [15:0] D2;
   logic        BUSY;

   modport slave  (input A2, inout C2, inout D2, output BUSY);
   modport master (output A2, inout C2, inout D2, input BUSY);
endinterface

// File: rtl/mem_ctrl.sv
// Line memory controller: 8-word line writes/reads on a shared tristate bus with fixed latency.
// Define MEM_STATS_EN to add saturating RD_COUNT/WR_COUNT statistics outputs.
module mem_ctrl #(
   parameter int MEM_LATENCY        = 4,
   parameter int MEM_LINE_ADDR_BITS = 15
) (
   input  logic        clk,
   input  logic        RESET,
   mem_ctrl_if.slave   bus
`ifdef MEM_STATS_EN
   ,
   output logic [15:0] RD_COUNT,
   output logic [15:0] WR_COUNT
`endif
);

   typedef enum logic [2:0] {IDLE, WR_RX, WAIT, RD_TX, WR_ACK, TURN} state_t;

   localparam int LINES = 1 << MEM_LINE_ADDR_BITS;

   state_t                          state_r;
   state_t                          after_wait_r;
   logic [7:0]                      cnt_r;
   logic [2:0]                      idx_r;
   logic [MEM_LINE_ADDR_BITS-1:0]   addr_r;
   logic [127:0]                    wbuf_r;
   logic [127:0]                    mem_r [LINES];
   logic                            drv_c2_r;
   logic                            drv_d2_r;
   logic [1:0]                      c2_out_r;
   logic [15:0]                     d2_out_r;
   logic                            busy_r;

   logic [1:0]                      c2_in_s;
   logic [15:0]                     d2_in_s;
   logic [127:0]                    rd_line_s;
   logic                            commit_s;
   logic                            rd_start_s;

   // Word i of a line occupies bytes 2i (high half) and 2i+1 (low half).
   function automatic logic [15:0] word_of(input logic [127:0] line, input logic [2:0] idx);
      logic [6:0] sh;
      sh = {3'd7 - idx, 4'b0000};
      return 16'(line >> sh);
   endfunction

   function automatic logic [127:0] put_word(input logic [127:0] line, input logic [2:0] idx,
                                             input logic [15:0] w);
      logic [6:0] sh;
      sh = {3'd7 - idx, 4'b0000};
      return (line & ~({112'd0, 16'hFFFF} << sh)) | ({112'd0, w} << sh);
   endfunction

   assign c2_in_s    = bus.C2;
   assign d2_in_s    = bus.D2;
   assign bus.C2     = drv_c2_r ? c2_out_r : 2'bzz;
   assign bus.D2     = drv_d2_r ? d2_out_r : 16'hzzzz;
   assign bus.BUSY   = busy_r;
   assign rd_line_s  = mem_r[addr_r];
   assign commit_s   = (state_r == WR_RX) && (idx_r == 3'd7);
   assign rd_start_s = (state_r == WAIT) && (cnt_r <= 8'd1) && (after_wait_r == RD_TX);

   // Controller FSM with registered bus drivers and BUSY.
   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         state_r      <= IDLE;
         after_wait_r <= IDLE;
         cnt_r        <= 8'd0;
         idx_r        <= 3'd0;
         addr_r       <= '0;
         wbuf_r       <= 128'd0;
         drv_c2_r     <= 1'b0;
         drv_d2_r     <= 1'b0;
         c2_out_r     <= 2'd0;
         d2_out_r     <= 16'd0;
         busy_r       <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (c2_in_s == 2'd2) begin
                  addr_r       <= bus.A2[MEM_LINE_ADDR_BITS-1:0];
                  cnt_r        <= 8'(MEM_LATENCY);
                  after_wait_r <= RD_TX;
                  state_r      <= WAIT;
                  busy_r       <= 1'b1;
               end else if (c2_in_s == 2'd3) begin
                  addr_r  <= bus.A2[MEM_LINE_ADDR_BITS-1:0];
                  wbuf_r  <= put_word(wbuf_r, 3'd0, d2_in_s);
                  idx_r   <= 3'd1;
                  state_r <= WR_RX;
                  busy_r  <= 1'b1;
               end
            end
            WR_RX: begin
               wbuf_r <= put_word(wbuf_r, idx_r, d2_in_s);
               if (idx_r == 3'd7) begin
                  idx_r        <= 3'd0;
                  cnt_r        <= 8'(MEM_LATENCY);
                  after_wait_r <= WR_ACK;
                  state_r      <= WAIT;
               end else begin
                  idx_r <= idx_r + 3'd1;
               end
            end
            WAIT: begin
               cnt_r <= cnt_r - 8'd1;
               if (cnt_r <= 8'd1) begin
                  cnt_r    <= 8'd0;
                  state_r  <= after_wait_r;
                  drv_c2_r <= 1'b1;
                  c2_out_r <= 2'd1;
                  if (after_wait_r == RD_TX) begin
                     drv_d2_r <= 1'b1;
                     d2_out_r <= word_of(rd_line_s, 3'd0);
                     idx_r    <= 3'd0;
                  end
               end
            end
            RD_TX: begin
               if (idx_r == 3'd7) begin
                  state_r  <= TURN;
                  drv_c2_r <= 1'b0;
                  drv_d2_r <= 1'b0;
                  idx_r    <= 3'd0;
               end else begin
                  idx_r    <= idx_r + 3'd1;
                  d2_out_r <= word_of(rd_line_s, idx_r + 3'd1);
               end
            end
            WR_ACK: begin
               state_r  <= TURN;
               drv_c2_r <= 1'b0;
            end
            TURN: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r  <= IDLE;
               busy_r   <= 1'b0;
               drv_c2_r <= 1'b0;
               drv_d2_r <= 1'b0;
            end
         endcase
      end
   end

   // Line array keeps its contents through reset; only a completed write updates it.
   always_ff @(posedge clk) begin
      if (commit_s) begin
         mem_r[addr_r] <= put_word(wbuf_r, 3'd7, d2_in_s);
      end
   end

`ifdef MEM_STATS_EN
   logic [15:0] rd_count_r;
   logic [15:0] wr_count_r;

   // Saturating read-burst and line-commit counters.
   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         rd_count_r <= 16'd0;
         wr_count_r <= 16'd0;
      end else begin
         if (rd_start_s && (rd_count_r != 16'hFFFF)) begin
            rd_count_r <= rd_count_r + 16'd1;
         end
         if (commit_s && (wr_count_r != 16'hFFFF)) begin
            wr_count_r <= wr_count_r + 16'd1;
         end
      end
   end

   assign RD_COUNT = rd_count_r;
   assign WR_COUNT = wr_count_r;
`else
   logic unused_s;
   assign unused_s = rd_start_s;
`endif

endmodule
